// File: rtl/uart_defs.sv
// 8N1 UART definitions: frame constants, receiver state encoding and baud divider math.
package uart_defs;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Clocks per oversample tick, truncated.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running clock divider; emits a one-clock tick every DIV clocks while restart is low.
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset || restart) cnt <= '0;
    else                   cnt <= (cnt == CW'(DIV - 1)) ? '0 : cnt + 1'b1;
  end

  assign tick = !restart && (cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronises RxD, samples mid-bit at OVERSAMPLE x baud, strobes valid/frame_err.
module uart_receiver
  import uart_defs::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);

  logic [1:0]           sync;
  logic                 rx_s;
  rx_state_e            state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 restart, tick, sample;

  assign rx_s    = sync[1];
  assign restart = (state == ST_IDLE);
  assign sample  = tick && (tick_cnt == TW'(OVERSAMPLE / 2 - 1));

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync      <= 2'b11;
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sync      <= {sync[0], RxD};
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (tick) tick_cnt <= (tick_cnt == TW'(OVERSAMPLE - 1)) ? '0 : tick_cnt + 1'b1;
      case (state)
        ST_IDLE: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
          if (!rx_s) begin
            state <= ST_START;
            busy  <= 1'b1;
          end
        end
        ST_START: if (sample) begin
          // Line back high at mid-start-bit: a glitch, not a frame.
          if (!rx_s) state <= ST_DATA;
          else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_DATA: if (sample) begin
          shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BW'(DATA_BITS - 1)) state <= ST_STOP;
        end
        ST_STOP: if (sample) begin
          data <= shreg;
          if (rx_s) begin
            valid <= 1'b1;
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            frame_err <= 1'b1;
            state     <= ST_BREAK;
          end
        end
        ST_BREAK: if (rx_s) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed + randomized frames on RxD, checked against a byte-level queue model of the receiver.
module tb_uart_receiver;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int OS       = 16;
  localparam int BIT      = 160;
  localparam int LATENCY  = BIT * 19 / 2 + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       RxD = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, busy;

  int errors = 0, checks = 0;
  int cyc = 0, both_cnt = 0, bad_busy = 0, busy_cnt = 0, last_fall = 0;
  logic [7:0] v_q[$], fe_q[$], exp_q[$];
  int         v_t[$];

  uart_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .reset     (reset),
    .RxD       (RxD),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Strobe monitor, sampled 1ns after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (valid) begin v_q.push_back(data); v_t.push_back(cyc); end
    if (frame_err) fe_q.push_back(data);
    if (valid && frame_err) both_cnt++;
    if ((valid && busy) || (frame_err && !busy)) bad_busy++;
    if (busy) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    RxD = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(1'b1, n);
  endtask

  // Caller sits on a negedge; line is left at the stop level.
  task automatic send_frame(input logic [7:0] b, input int bl, input logic stop, input int stop_len);
    last_fall = cyc;
    drive(1'b0, bl);
    for (int i = 0; i < 8; i++) drive(b[i], bl);
    drive(stop, bl * stop_len);
    if (stop) exp_q.push_back(b);
  endtask

  task automatic check_queue(input string tag);
    chk({tag, "_count"}, v_q.size(), exp_q.size());
    for (int i = 0; i < v_q.size() && i < exp_q.size(); i++)
      chk({tag, "_data"}, v_q[i], exp_q[i]);
    v_q.delete(); v_t.delete(); exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    int gap, bl;

    repeat (4) @(negedge clk);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b1;
    idle(20);

    // Single good frame: exact latency and busy behaviour.
    send_frame(8'hA5, BIT, 1'b1, 1);
    idle(10);
    chk("a5_count1", v_q.size(), 1);
    if (v_t.size() > 0) chk("a5_latency", v_t[0] - last_fall, LATENCY);
    chk("a5_ferr", fe_q.size(), 0);
    check_queue("a5");

    // Back-to-back frames, no idle gap.
    send_frame(8'h00, BIT, 1'b1, 1);
    send_frame(8'hFF, BIT, 1'b1, 1);
    idle(10);
    if (v_t.size() == 2) chk("b2b_interval", v_t[1] - v_t[0], 10 * BIT);
    else chk("b2b_pulses", v_t.size(), 2);
    check_queue("b2b");

    // Start-bit glitch.
    busy_cnt = 0;
    drive(1'b0, 60);
    idle(300);
    chk("glitch_busy_len", (busy_cnt > 0 && busy_cnt <= 80), 1);
    chk("glitch_busy", busy, 1'b0);
    chk("glitch_ferr", fe_q.size(), 0);
    check_queue("glitch");

    // Stop bit held low: frame error, then BREAK until line goes high.
    send_frame(8'h3C, BIT, 1'b0, 3);
    chk("fe_count", fe_q.size(), 1);
    if (fe_q.size() > 0) chk("fe_byte", fe_q[0], 8'h3C);
    chk("fe_data", data, 8'h3C);
    chk("fe_busy_held", busy, 1'b1);
    chk("fe_no_valid", v_q.size(), 0);
    idle(5);
    chk("fe_busy_release", busy, 1'b0);
    fe_q.delete();
    idle(20);
    send_frame(8'h81, BIT, 1'b1, 1);
    idle(10);
    check_queue("after_break");

    // Reset in the middle of bit 4 of 0x55.
    b = 8'h55;
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(b[i], BIT);
    drive(b[4], BIT / 2);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_data", data, 8'h00);
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_ferr", frame_err, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    idle(1700);
    chk("mid_rst_no_strobe", v_q.size() + fe_q.size(), 0);
    send_frame(8'h99, BIT, 1'b1, 1);
    idle(10);
    check_queue("post_rst");

    // Baud mismatch of about +/-3%.
    send_frame(8'hC3, 155, 1'b1, 1);
    idle(30);
    send_frame(8'hC3, 165, 1'b1, 1);
    idle(10);
    check_queue("baud_skew");

    // Random bytes, random gaps and small rate skew.
    for (int n = 0; n < 10; n++) begin
      b   = 8'($urandom);
      gap = $urandom_range(0, 300);
      bl  = $urandom_range(156, 164);
      idle(gap);
      send_frame(b, bl, 1'b1, 1);
    end
    idle(50);
    chk("rand_ferr", fe_q.size(), 0);
    check_queue("rand");

    chk("strobe_overlap", both_cnt, 0);
    chk("busy_at_strobe", bad_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver, 8N1, LSB first: the receive-side counterpart of the existing transmitter path. It synchronises the asynchronous `RxD` pin, oversamples it at 16× baud, validates the start bit, assembles one byte and presents it for a single clock with a valid strobe. It sits between the board RX pin and the LED/debug logic in the top level, sharing `clk` and `reset` with the transmitter.

## Interface
- `CLK_FREQ`, 100_000_000, system clock frequency in Hz
- `BAUD`, 9600, line rate in bit/s
- `OVERSAMPLE`, 16, ticks per bit period; must be even and ≥ 8
- `clk`  input  1  system clock; all logic on the rising edge
- `reset`  input  1  one clock; reset is synchronous and active-low (`reset`=0 clears on the next `clk` edge)
- `RxD`  input  1  asynchronous serial line, idle high
- `data`  output  8  last received byte; holds until the next frame completes
- `valid`  output  1  one-cycle strobe: `data` updated with a good frame
- `frame_err`  output  1  one-cycle strobe: stop bit sampled low
- `busy`  output  1  high from accepted start edge until return to IDLE

## Operation
- Input: 2-FF synchroniser on `RxD`; both flops reset to 1. All logic uses the synchronised copy `rx_s`.
- Tick generator: `DIV = CLK_FREQ / (BAUD*OVERSAMPLE)`, integer truncation (651 at defaults). It free-runs while not IDLE and restarts at 0 on the start edge. A `tick` pulse lasts one clock every `DIV` clocks.
- Sample point: tick index `OVERSAMPLE/2 - 1` (tick 7) within each bit. A 4-bit tick counter wraps at `OVERSAMPLE-1`. A 3-bit bit counter runs 0..7.
- FSM states:
  - IDLE: `busy`=0. On `rx_s`=0, go to START and clear the counters.
  - START: at the sample point, if `rx_s`=0, go to DATA. If `rx_s`=1, treat it as a glitch and return to IDLE with no strobe.
  - DATA: at each sample point, shift `rx_s` into the MSB of the shift register (LSB arrives first). After bit 7, go to STOP.
  - STOP: at the sample point:
    - `rx_s`=1: load `data` from the shift register, pulse `valid`, return to IDLE.
    - `rx_s`=0: load `data`, pulse `frame_err` (no `valid`), go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. `busy` stays 1.
- `valid` and `frame_err` are never high in the same cycle.
- Reset values: `data`=8'h00, `valid`=0, `frame_err`=0, `busy`=0, FSM=IDLE, counters=0, synchroniser=1.
- Reset mid-frame: abort immediately, discard partial bits, no strobe. After reset release, wait for a fresh falling edge.
- No receive FIFO. A consumer that misses `valid` loses the byte. Overrun cannot occur because `data` is only overwritten by a complete frame.

## Timing
- Start-edge detection latency: 2 clocks (synchroniser) plus 1 clock (IDLE→START).
- `valid` or `frame_err` asserts exactly one clock after the stop-bit sample edge. Nominally ≈ 9.5 bit periods after the `RxD` falling edge, plus 3 clocks.
- Return to IDLE occurs in the same cycle as `valid`, so a back-to-back start bit is detected half a bit after the stop sample. Line-rate frames with one stop bit are accepted continuously.
- Tolerated baud mismatch: ±4% (sampling at mid-bit with 16× oversampling).

## Structure
- Shared package/header `uart_defs`: FSM state encoding (IDLE, START, DATA, STOP, BREAK), the `DIV` calculation, and the 8N1 frame constants (`DATA_BITS`=8, `STOP_BITS`=1). The transmitter is reworked to use the same constants.
- Sub-module `uart_baud_tick`: parameterised divider with a `restart` input and a `tick` output, reusable by the transmitter. Synchroniser, FSM and shift register live in `uart_receiver`.
- Target size: ~150–250 lines RTL.

## Test plan
Bench parameters: `CLK_FREQ`=1_600_000, `BAUD`=10_000, giving `DIV`=10 and 160 clocks per bit.
- Frame 0xA5 with stop=1 → `valid` pulses for one cycle with `data`=8'hA5, `frame_err`=0, `busy` falls in the same cycle.
- Two back-to-back frames 0x00 then 0xFF, no idle gap → two `valid` pulses 1600 clocks apart, `data` = 0x00 then 0xFF.
- `RxD` low pulse of 60 clocks (shorter than half a bit) → no strobe, FSM returns to IDLE, `busy` high for ≤ 80 clocks.
- Frame 0x3C with stop bit held low for 3 bit times → `frame_err` pulses once, `valid`=0, `data`=8'h3C, `busy` stays 1 until `RxD` returns high, then the next frame 0x81 is received correctly.
- `reset`=0 for 2 clocks in the middle of bit 4 of frame 0x55 → all outputs return to reset values, no strobe for that frame, the following frame 0x99 yields `valid` with `data`=8'h99.
- Frame 0xC3 sent at baud +3% and −3% → `valid` with `data`=8'hC3 in both cases.
